// File: rtl/uart_tx_engine.sv
// uart_tx_engine -- 8-bit asynchronous serial transmitter.
//
// Sends one frame per accepted load. The frame is a start bit (0), data[0]
// through data[7] LSB first, an optional parity bit, and STOP_BITS stop bits
// (1). Every bit lasts bit_time clocks. bit_time, data and odd are captured at
// acceptance, so later changes to the inputs do not affect the frame in flight.
//
// Optional feature: define TX_PARITY_EN to insert a parity bit after data[7].
// The parity bit is the XOR of the eight data bits XOR odd.
//
// Parameters:
//   STOP_BITS  stop bits per frame (1 or 2)
// Ports:
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   bit_time  in   [18:0] clocks per bit; 0 disables the transmitter
//   load      in   single-cycle transmit request
//   data      in   [7:0] byte to send, valid with load
//   odd       in   parity sense (1 = odd); ignored without TX_PARITY_EN
//   tx        out  registered serial line, idles high
//   tx_rdy    out  high when a load would be accepted
//   tx_done   out  one-cycle pulse as the last stop bit completes
module uart_tx_engine #(
  parameter int unsigned STOP_BITS = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [18:0] bit_time,
  input  logic        load,
  input  logic [7:0]  data,
  input  logic        odd,
  output logic        tx,
  output logic        tx_rdy,
  output logic        tx_done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // Value of the stop index during the final stop bit.
  localparam logic STOP_LAST = (STOP_BITS == 2);

  state_t      state_q;
  logic        tx_q;
  logic        done_q;
  logic [18:0] cnt_q;
  logic [18:0] bt_q;
  logic [7:0]  data_q;
  logic [2:0]  idx_q;
  logic        stop_q;
  logic [2:0]  idx_d;

`ifdef TX_PARITY_EN
  logic        odd_q;
  logic        par_d;
  assign par_d = (^data_q) ^ odd_q;
`else
  logic        unused_odd;
  assign unused_odd = odd;
`endif

  assign idx_d = idx_q + 3'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      bt_q    <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
`ifdef TX_PARITY_EN
      odd_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (load && (bit_time != '0)) begin
            data_q  <= data;
            bt_q    <= bit_time;
`ifdef TX_PARITY_EN
            odd_q   <= odd;
`endif
            cnt_q   <= bit_time - 19'd1;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        default: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 19'd1;
          end else begin
            // Current bit has lasted bt_q clocks: present the next one.
            cnt_q <= bt_q - 19'd1;
            case (state_q)
              START: begin
                idx_q   <= '0;
                tx_q    <= data_q[0];
                state_q <= DATA;
              end
              DATA: begin
                if (idx_q == 3'd7) begin
`ifdef TX_PARITY_EN
                  tx_q    <= par_d;
                  state_q <= PARITY;
`else
                  tx_q    <= 1'b1;
                  stop_q  <= 1'b0;
                  state_q <= STOP;
`endif
                end else begin
                  idx_q <= idx_d;
                  tx_q  <= data_q[idx_d];
                end
              end
`ifdef TX_PARITY_EN
              PARITY: begin
                tx_q    <= 1'b1;
                stop_q  <= 1'b0;
                state_q <= STOP;
              end
`endif
              STOP: begin
                tx_q <= 1'b1;
                if (stop_q == STOP_LAST) begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
                end else begin
                  stop_q <= 1'b1;
                end
              end
              default: begin
                tx_q    <= 1'b1;
                state_q <= IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign tx      = tx_q;
  assign tx_done = done_q;
  assign tx_rdy  = (state_q == IDLE) && (bit_time != '0);

endmodule

// File: tb/tb_uart_tx_engine.sv
module tb_uart_tx_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [18:0] bt1 = '0, bt2 = '0;
  logic        load1 = 1'b0, load2 = 1'b0;
  logic [7:0]  data1 = '0, data2 = '0;
  logic        odd = 1'b0;
  logic        tx1, rdy1, done1, tx2, rdy2, done2;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_tx_engine u_dut1 (
    .clk(clk), .reset_n(reset_n), .bit_time(bt1), .load(load1), .data(data1),
    .odd(odd), .tx(tx1), .tx_rdy(rdy1), .tx_done(done1)
  );

  uart_tx_engine #(.STOP_BITS(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .bit_time(bt2), .load(load2), .data(data2),
    .odd(odd), .tx(tx2), .tx_rdy(rdy2), .tx_done(done2)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input bit sel, input logic [18:0] b, input logic [7:0] d, input logic ld);
    if (sel) begin
      bt2 = b; data2 = d; load2 = ld;
    end else begin
      bt1 = b; data1 = d; load1 = ld;
    end
  endtask

  // Sends one frame and checks tx every cycle. Bit j occupies cycles
  // j*b+1 .. (j+1)*b after the accepting edge; tx_done is seen in cycle total+1.
  // poke > 0: at that cycle pulse load with data 00 and switch bit_time to
  // poke_bt; poke < 0: pulse load in the last cycle of the frame.
  task automatic frame(input bit sel, input int b, input logic [7:0] d, input bit par,
                       input bit pbit, input int nstop, input int poke,
                       input logic [18:0] poke_bt, input string tag);
    logic        bits[16];
    int          nb;
    int          total;
    int          pk;
    logic [18:0] cbt;
    logic [7:0]  cd;
    nb = 1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin bits[nb] = d[i]; nb++; end
    if (par) begin bits[nb] = pbit; nb++; end
    for (int i = 0; i < nstop; i++) begin bits[nb] = 1'b1; nb++; end
    total = nb * b;
    pk = (poke < 0) ? total : poke;
    cbt = 19'(b);
    cd = d;
    set_in(sel, cbt, cd, 1'b0);
    #1;
    chk({tag, ".rdy_pre"}, sel ? rdy2 : rdy1, 1);
    set_in(sel, cbt, cd, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_in(sel, cbt, cd, 1'b0);
    for (int c = 1; c <= total; c++) begin
      chk({tag, ".tx"}, sel ? tx2 : tx1, bits[(c - 1) / b]);
      chk({tag, ".rdy_busy"}, sel ? rdy2 : rdy1, 0);
      chk({tag, ".done_busy"}, sel ? done2 : done1, 0);
      if (c == pk) begin
        cbt = poke_bt; cd = 8'h00;
        set_in(sel, cbt, cd, 1'b1);
      end else if (c == pk + 1) begin
        set_in(sel, cbt, cd, 1'b0);
      end
      @(negedge clk);
    end
    set_in(sel, cbt, cd, 1'b0);
    #1;
    chk({tag, ".done"}, sel ? done2 : done1, 1);
    chk({tag, ".rdy_done"}, sel ? rdy2 : rdy1, 1);
    chk({tag, ".tx_done_cyc"}, sel ? tx2 : tx1, 1);
    @(negedge clk);
    chk({tag, ".done_once"}, sel ? done2 : done1, 0);
  endtask

  task automatic idle_check(input bit sel, input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      chk({tag, ".tx_idle"}, sel ? tx2 : tx1, 1);
      chk({tag, ".done_idle"}, sel ? done2 : done1, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst.tx1", tx1, 1);
    chk("rst.done1", done1, 0);
    chk("rst.rdy1_bt0", rdy1, 0);
    chk("rst.tx2", tx2, 1);
    chk("rst.done2", done2, 0);
    reset_n = 1'b1;
    bt1 = 19'd5;
    #1;
    chk("rst.rdy1_first", rdy1, 1);
    @(negedge clk);

    // Basic frame A5 at 5 clocks/bit: 0,1,0,1,0,0,1,0,1,1 and done at 50.
    frame(1'b0, 5, 8'hA5, PAR, 1'b0, 1, 0, 19'd0, "a5");
    idle_check(1'b0, 5, "a5_after");

    // bit_time == 0: transmitter disabled, load ignored.
    set_in(1'b0, 19'd0, 8'hFF, 1'b1);
    #1;
    chk("bt0.rdy_at_load", rdy1, 0);
    @(negedge clk);
    set_in(1'b0, 19'd0, 8'hFF, 1'b0);
    for (int c = 0; c < 20; c++) begin
      chk("bt0.tx", tx1, 1);
      chk("bt0.rdy", rdy1, 0);
      chk("bt0.done", done1, 0);
      @(negedge clk);
    end

`ifdef TX_PARITY_EN
    odd = 1'b0;
    frame(1'b0, 4, 8'h03, 1'b1, 1'b0, 1, 0, 19'd0, "par_even");
    odd = 1'b1;
    frame(1'b0, 4, 8'h03, 1'b1, 1'b1, 1, 0, 19'd0, "par_odd");
    odd = 1'b0;
`else
    // odd has no effect without parity: 03 frame is 10 bits.
    odd = 1'b1;
    frame(1'b0, 4, 8'h03, 1'b0, 1'b0, 1, 0, 19'd0, "odd_ignored");
    odd = 1'b0;
`endif

    // Mid-frame load of 00 and bit_time change to 7 are ignored.
    frame(1'b0, 3, 8'h5A, PAR, 1'b0, 1, 10, 19'd7, "mid");
    idle_check(1'b0, 30, "mid_no_second");

    // Load held across the edge that ends the frame is ignored.
    frame(1'b0, 3, 8'h3C, PAR, 1'b0, 1, -1, 19'd3, "coinc");
    idle_check(1'b0, 20, "coinc_no_second");

    // Reset during data bit 4 (frame bit 5, cycles 26..30 at 5 clocks/bit).
    set_in(1'b0, 19'd5, 8'hA5, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_in(1'b0, 19'd5, 8'hA5, 1'b0);
    repeat (26) @(negedge clk);
    chk("rstmid.tx_pre", tx1, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid.tx_async", tx1, 1);
    chk("rstmid.done_async", done1, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle_check(1'b0, 60, "rstmid_idle");
    frame(1'b0, 5, 8'hA5, PAR, 1'b0, 1, 0, 19'd0, "post_rst");

    // Two stop bits: 80 at 2 clocks/bit, stop level 4 cycles, done at 22.
    frame(1'b1, 2, 8'h80, PAR, 1'b1, 2, 0, 19'd0, "stop2");
    idle_check(1'b1, 5, "stop2_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
